fib_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative Fibonacci engine between NREQ requesters. It captures a requester's index, launches the engine with a one-cycle start pulse, waits for the engine's ready, and returns the result to the granted requester with a one-cycle done strobe. A watchdog aborts a launch whose ready never arrives. It sits between the client logic and the single engine instance.

---
 rtl/fib_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/fib_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fib_arb_pkg.sv
// Shared types and defaults for the Fibonacci engine arbiter.
package fib_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StGuard,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefNw      = 4;
  localparam int unsigned DefOw      = 11;
  localparam int unsigned DefTimeout = 64;

  // Watchdog counter only needs to reach TIMEOUT-1.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IW-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = IW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin sequencer sharing one iterative Fibonacci engine between NREQ requesters,
// with a watchdog that aborts a launch whose ready never returns.
module fib_arbiter
  import fib_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NW      = DefNw,
  parameter int unsigned OW      = DefOw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*NW-1:0] req_n_i,
  output logic [NREQ-1:0]  done_o,
  output logic [OW-1:0]    result_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             eng_start_o,
  output logic [NW-1:0]    eng_n_o,
  input  logic             eng_ready_i,
  input  logic [OW-1:0]    eng_out_i
);

  localparam int unsigned IW = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [NW-1:0]   eng_n_q;
  logic [OW-1:0]   result_q;
  logic            err_q;
  logic            busy_q;
  logic            eng_start_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [NW-1:0]   pick_n;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign pick_n = req_n_i[NW*pick_idx +: NW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      eng_n_q     <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Strobes default low so they only live for the one state that raises them.
      eng_start_q <= 1'b0;
      done_q      <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_any && eng_ready_i) begin
            idx_q       <= pick_idx;
            gnt_q       <= pick_gnt;
            eng_n_q     <= pick_n;
            busy_q      <= 1'b1;
            eng_start_q <= 1'b1;
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          cnt_q   <= '0;
          state_q <= StGuard;
        end
        StGuard: begin
          state_q <= StWait;
        end
        StWait: begin
          if (eng_ready_i) begin
            result_q <= eng_out_i;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            state_q  <= StDone;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_q <= '1;
            err_q    <= 1'b1;
            done_q   <= gnt_q;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          ptr_q   <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign done_o      = done_q;
  assign result_o    = result_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign eng_start_o = eng_start_q;
  assign eng_n_o     = eng_n_q;

endmodule
